// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: packs field-level RV32I descriptors into words and writes them to consecutive imem addresses.
// Optional immediate range checking is enabled by defining LOADER_IMM_RANGECHECK_EN.
module instr_encoder_loader #(
   parameter int ADDR_W    = 10,
   parameter int BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        in_fmt,
   input  logic [6:0]        in_opcode,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_rs1,
   input  logic [4:0]        in_rs2,
   input  logic [2:0]        in_funct3,
   input  logic [6:0]        in_funct7,
   input  logic [31:0]       in_imm,
   input  logic              in_last,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W:0]   count
);
   typedef enum logic [1:0] {IDLE, ACCEPT, WRITE, DONE} state_t;
   state_t            state;
   logic [ADDR_W-1:0] ptr;
   logic              last_q;
   logic [31:0]       word;
   logic              fmt_bad;
   logic              rng_bad;

   assign word =
      in_fmt == 3'd0 ? {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode} :
      in_fmt == 3'd1 ? {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode} :
      in_fmt == 3'd2 ? {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode} :
      in_fmt == 3'd3 ? {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3, in_imm[4:1], in_imm[11], in_opcode} :
      in_fmt == 3'd4 ? {in_imm[31:12], in_rd, in_opcode} :
      in_fmt == 3'd5 ? {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode} :
      32'h0000_0013;
   assign fmt_bad = in_fmt > 3'd5;

`ifdef LOADER_IMM_RANGECHECK_EN
   logic sx12, sx13, sx21;
   assign sx12 = in_imm[31:11] == {21{in_imm[11]}};
   assign sx13 = in_imm[31:12] == {20{in_imm[12]}};
   assign sx21 = in_imm[31:20] == {12{in_imm[20]}};
   assign rng_bad =
      (in_fmt == 3'd1 || in_fmt == 3'd2) ? !sx12 :
      in_fmt == 3'd3 ? (!sx13 || in_imm[0]) :
      in_fmt == 3'd4 ? |in_imm[11:0] :
      in_fmt == 3'd5 ? (!sx21 || in_imm[0]) :
      1'b0;
`else
   assign rng_bad = 1'b0;
`endif

   assign in_ready = state == ACCEPT;
   assign mem_we   = state == WRITE;
   assign busy     = state == ACCEPT || state == WRITE;
   assign done     = state == DONE;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         ptr       <= '0;
         last_q    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         count     <= '0;
         err       <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: if (start) begin
               ptr   <= ADDR_W'(BASE_ADDR);
               count <= '0;
               err   <= 1'b0;
               state <= ACCEPT;
            end
            ACCEPT: if (in_valid) begin
               mem_addr  <= ptr;
               mem_wdata <= word;
               last_q    <= in_last;
               err       <= err | fmt_bad | rng_bad;
               state     <= WRITE;
            end
            WRITE: begin
               count <= count + 1'b1;
               // the all-ones address is the last slot; running past it without in_last is an overflow
               if (last_q || &ptr) begin
                  state <= DONE;
                  if (!last_q) err <= 1'b1;
               end else begin
                  ptr   <= ptr + 1'b1;
                  state <= ACCEPT;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb_instr_encoder_loader: randomized and directed check of instr_encoder_loader against a field-placement reference model.
module tb_instr_encoder_loader;
   localparam int AW = 10;
   logic          clk = 1'b0;
   logic          rst, start, in_valid, in_last;
   logic          in_ready, mem_we, busy, done, err;
   logic [2:0]    in_fmt, in_funct3;
   logic [6:0]    in_opcode, in_funct7;
   logic [4:0]    in_rd, in_rs1, in_rs2;
   logic [31:0]   in_imm, mem_wdata;
   logic [AW-1:0] mem_addr;
   logic [AW:0]   count;
   int            total = 0, bad = 0;
   logic [31:0]   qa[$], qd[$];
   int            exp_ptr;
   logic          exp_err;

   always #5 clk = ~clk;

   instr_encoder_loader #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
      .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm), .in_last(in_last),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .busy(busy), .done(done), .err(err), .count(count)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Instruction fields placed by shifting and masking each immediate slice into position.
   function automatic logic [31:0] model(input int f, input logic [31:0] op, rd, rs1, rs2, f3, f7, u);
      case (f)
         0: return op | rd << 7 | f3 << 12 | rs1 << 15 | rs2 << 20 | f7 << 25;
         1: return op | rd << 7 | f3 << 12 | rs1 << 15 | (u & 32'hFFF) << 20;
         2: return op | (u & 32'd31) << 7 | f3 << 12 | rs1 << 15 | rs2 << 20 | ((u >> 5) & 32'd127) << 25;
         3: return op | ((u >> 11) & 32'd1) << 7 | ((u >> 1) & 32'd15) << 8 | f3 << 12 | rs1 << 15
                   | rs2 << 20 | ((u >> 5) & 32'd63) << 25 | ((u >> 12) & 32'd1) << 31;
         4: return op | rd << 7 | (u & 32'hFFFF_F000);
         5: return op | rd << 7 | ((u >> 12) & 32'd255) << 12 | ((u >> 11) & 32'd1) << 20
                   | ((u >> 1) & 32'd1023) << 21 | ((u >> 20) & 32'd1) << 31;
         default: return 32'h0000_0013;
      endcase
   endfunction

   function automatic bit imm_bad(input int f, input int v);
      case (f)
         1, 2:    return v < -2048 || v > 2047;
         3:       return v < -4096 || v > 4095 || v % 2 != 0;
         4:       return v % 4096 != 0;
         5:       return v < -1048576 || v > 1048575 || v % 2 != 0;
         default: return 1'b0;
      endcase
   endfunction

   task automatic do_start();
      start = 1'b1;
      @(posedge clk); #1;
      start   = 1'b0;
      exp_ptr = 0;
      exp_err = 1'b0;
   endtask

   task automatic send(input int f, input logic [6:0] op, input logic [4:0] rd, rs1, rs2,
                       input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm,
                       input logic last, input logic [31:0] exp);
      bit ok = 1'b0;
      in_fmt = f[2:0]; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
      in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_last = last; in_valid = 1'b1;
      qa.push_back(32'(exp_ptr));
      qd.push_back(exp);
      exp_ptr++;
      if (f > 5) exp_err = 1'b1;
`ifdef LOADER_IMM_RANGECHECK_EN
      if (imm_bad(f, int'(imm))) exp_err = 1'b1;
`endif
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         if (in_ready) begin
            @(posedge clk); #1;
            ok = 1'b1;
         end
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (!ok) chk("accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic rnd_send(input logic last);
      logic [31:0] op, rd, rs1, rs2, f3, f7, u;
      int f, v;
      f  = $urandom_range(0, 7);
      op = $urandom & 32'd127; rd = $urandom & 32'd31; rs1 = $urandom & 32'd31; rs2 = $urandom & 32'd31;
      f3 = $urandom & 32'd7;  f7 = $urandom & 32'd127;
      v  = $urandom_range(0, 1) ? int'($urandom) : int'($urandom_range(0, 8191)) - 4096;
      u  = v;
      send(f, op[6:0], rd[4:0], rs1[4:0], rs2[4:0], f3[2:0], f7[6:0], u, last, model(f, op, rd, rs1, rs2, f3, f7, u));
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_ready"}, 32'(in_ready), 0);
      chk({tag, "_we"}, 32'(mem_we), 0);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_done"}, 32'(done), 0);
      chk({tag, "_err"}, 32'(err), 0);
      chk({tag, "_addr"}, 32'(mem_addr), 0);
      chk({tag, "_wdata"}, mem_wdata, 0);
      chk({tag, "_count"}, 32'(count), 0);
   endtask

   always @(negedge clk) begin
      if (!rst && mem_we) begin
         if (qd.size() == 0) chk("extra_write", 32'd1, 32'd0);
         else begin
            chk("wr_addr", 32'(mem_addr), qa.pop_front());
            chk("wr_data", mem_wdata, qd.pop_front());
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
      in_fmt = '0; in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
      in_funct3 = '0; in_funct7 = '0; in_imm = '0;
      exp_ptr = 0; exp_err = 1'b0;
      repeat (3) @(negedge clk);
      chk_reset_state("reset");
      @(posedge clk); #1;
      rst = 1'b0;
      start = 1'b1; in_valid = 1'b1;
      @(negedge clk);
      chk("ready_with_start", 32'(in_ready), 0);
      @(posedge clk); #1;
      start = 1'b0; in_valid = 1'b0; exp_ptr = 0; exp_err = 1'b0;
      @(negedge clk);
      chk("ready_after_start", 32'(in_ready), 1);
      chk("busy_accept", 32'(busy), 1);
      @(posedge clk); #1;
      send(1, 7'h13, 5'd1, 5'd0, 5'($urandom), 3'd0, 7'($urandom), 32'd5, 1'b0, 32'h0050_0093);
      send(2, 7'h23, 5'($urandom), 5'd1, 5'd2, 3'd2, 7'($urandom), 32'd8, 1'b0, 32'h0020_A423);
      send(3, 7'h63, 5'($urandom), 5'd1, 5'd2, 3'd0, 7'($urandom), 32'hFFFF_FFFC, 1'b0, 32'hFE20_8EE3);
      send(5, 7'h6F, 5'd1, 5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom), 32'd2048, 1'b0, 32'h0010_00EF);
      send(4, 7'h37, 5'd5, 5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom), 32'h1234_5000, 1'b1, 32'h1234_52B7);
      repeat (2) @(negedge clk);
      chk("dir_done", 32'(done), 1);
      chk("dir_count", 32'(count), 5);
      chk("dir_err", 32'(err), 0);
      chk("dir_busy", 32'(busy), 0);
      chk("dir_ready", 32'(in_ready), 0);
      @(posedge clk); #1;
      do_start();
      send(7, 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom), $urandom, 1'b1, 32'h0000_0013);
      repeat (2) @(negedge clk);
      chk("illegal_err", 32'(err), 1);
      chk("illegal_done", 32'(done), 1);
      chk("illegal_count", 32'(count), 1);
      @(posedge clk); #1;
      do_start();
      @(negedge clk);
      chk("err_cleared", 32'(err), 0);
      chk("done_cleared", 32'(done), 0);
      @(posedge clk); #1;
      send(1, 7'h13, 5'd1, 5'd0, 5'($urandom), 3'd0, 7'($urandom), 32'd4096, 1'b1, 32'h0000_0093);
      repeat (2) @(negedge clk);
`ifdef LOADER_IMM_RANGECHECK_EN
      chk("range_err", 32'(err), 1);
`else
      chk("range_err", 32'(err), 0);
`endif
      chk("range_done", 32'(done), 1);
      @(posedge clk); #1;
      do_start();
      for (int i = 0; i < 30; i++) rnd_send(i == 29);
      repeat (2) @(negedge clk);
      chk("rnd_done", 32'(done), 1);
      chk("rnd_count", 32'(count), 30);
      chk("rnd_err", 32'(err), 32'(exp_err));
      @(posedge clk); #1;
      do_start();
      rnd_send(1'b0);
      chk("we_before_rst", 32'(mem_we), 1);
      rst = 1'b1;
      #1;
      chk("we_async_drop", 32'(mem_we), 0);
      chk_reset_state("midrst");
      qa.delete();
      qd.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      do_start();
      for (int i = 0; i < (1 << AW); i++) rnd_send(1'b0);
      repeat (2) @(negedge clk);
      chk("ovf_done", 32'(done), 1);
      chk("ovf_count", 32'(count), 1 << AW);
      chk("ovf_err", 32'(err), 1);
      in_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("ovf_no_accept", 32'(in_ready), 0);
      end
      in_valid = 1'b0;
      chk("sb_drain", 32'(qd.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/instr_encoder_loader.md
# instr_encoder_loader

- Writer-side counterpart to the instruction decode path.
- Accepts field-level instruction descriptions (format, opcode, registers, funct fields, full 32-bit immediate) over a valid/ready handshake.
- Packs each one into a 32-bit RV32I instruction word using the R/I/S/B/U/J layouts.
- Writes the words into instruction memory at consecutive word addresses.
- Used by the boot/self-test path to build programs that the fetch/decode path then executes.

## Interface
- ADDR_W, 10, instruction-memory word-address width
- BASE_ADDR, 0, first word address written after start
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  pulse; begins a load session (honoured only in IDLE or DONE)
- in_valid  in  1  descriptor valid
- in_ready  out  1  descriptor accepted when in_valid & in_ready
- in_fmt  in  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6,7 illegal
- in_opcode  in  7  opcode field
- in_rd / in_rs1 / in_rs2  in  5 each  register fields
- in_funct3  in  3; in_funct7  in  7
- in_imm  in  32  full signed immediate (byte offset for B/J; upper-aligned for U)
- in_last  in  1  final descriptor of session
- mem_we  out  1  write strobe
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  32  encoded instruction
- busy  out  1  session in progress (ACCEPT or WRITE)
- done  out  1  session finished; held until next start
- err  out  1  sticky error; cleared by start
- count  out  ADDR_W+1  words written this session

## Operation
- FSM states: IDLE, ACCEPT, WRITE, DONE.
- **IDLE / DONE**
  - in_ready=0.
  - On start: ptr=BASE_ADDR, count=0, err=0, done=0, go to ACCEPT.
- **ACCEPT**
  - in_ready=1.
  - On handshake: register encoded word, in_last, and the current ptr; go to WRITE.
  - start is ignored.
- **WRITE**
  - mem_we=1 for exactly one cycle with the registered addr and word; count++.
  - If in_last was set, or ptr == 2^ADDR_W−1: go to DONE. The all-ones case also sets err (overflow) if in_last was not set.
  - Otherwise: ptr++, go to ACCEPT.
  - start is ignored.
- **Encoding** (bit fields, MSB→LSB):
  - R: funct7|rs2|rs1|f3|rd|op
  - I: imm[11:0]|rs1|f3|rd|op
  - S: imm[11:5]|rs2|rs1|f3|imm[4:0]|op
  - B: imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11]|op
  - U: imm[31:12]|rd|op
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op
- **Ignored inputs:**
  - Fields unused by a format are ignored.
  - Immediate bits outside the format are dropped by truncation.
- **Illegal in_fmt:** word is 32'h00000013 (NOP); err set; still written.

## Timing
- **Reset:** state=IDLE; in_ready, mem_we, busy, done, err = 0; mem_addr=0, mem_wdata=0, count=0.
- **Write latency:** handshake in cycle N → mem_we in cycle N+1. mem_addr/mem_wdata are registered and stable while mem_we=1.
- **Throughput:** at most one word per 2 cycles.
- **State outputs:**
  - busy=1 in ACCEPT and WRITE.
  - done rises the cycle after the last WRITE.
- **Reset mid-session:** immediate abort to IDLE. A write in progress is dropped (mem_we deasserts asynchronously).
- **start with in_valid in the same cycle (IDLE):** no accept that cycle; in_ready rises next cycle.
- **Overflow:** after writing the all-ones address, no further descriptors are accepted. in_valid stays pending with in_ready=0.

## Configuration
- Macro: LOADER_IMM_RANGECHECK_EN.
- **Defined:** err also sets when in_imm is not representable in the format:
  - I/S: not a 12-bit sign extension.
  - B: not a 13-bit sign extension, or imm[0]≠0.
  - J: not a 21-bit sign extension, or imm[0]≠0.
  - U: imm[11:0]≠0.
  - The truncated word is still written.
- **Undefined:** no range checking. Truncation is silent; err comes only from illegal in_fmt or overflow.

## Test plan
- **Reset/idle:** assert rst mid-WRITE → mem_we=0 the same cycle; all outputs at reset values.
- **I and S formats:**
  - start; ADDI x1,x0,5 (fmt1, op 0x13) → mem_addr 0, 0x00500093.
  - SW x2,8(x1) (fmt2, op 0x23, f3 2) → addr 1, 0x0020A423.
- **B, J and U formats:**
  - BEQ x1,x2,−4 (fmt3, op 0x63) → 0xFE208EE3.
  - JAL x1,2048 (fmt5, op 0x6F) → 0x001000EF.
  - LUI x5,0x12345000 (fmt4, op 0x37, in_last=1) → 0x123452B7; then done=1, count=5.
- **Illegal format:** in_fmt=7 → 0x00000013 written; err=1; err cleared by next start.
- **Overflow (ADDR_W=2):** 5 descriptors, none with in_last → addresses 0..3 written; err=1, done=1, count=4; 5th descriptor never accepted.
- **Range check:** ADDI imm=4096 → word 0x00000093 in both builds; err=1 with LOADER_IMM_RANGECHECK_EN, err=0 without.
